// File: rtl/axis_pkt_demux.sv
// rtl/axis_pkt_demux.sv - packet-aware AXI-Stream 1:NUM_CH demux with registered output stage.
// Optional dropped-packet counter is enabled by defining AXIS_DEMUX_DROP_CNT_EN.
module axis_pkt_demux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               bus_sel,
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]        m_axis_tvalid,
   output logic [NUM_CH-1:0]        m_axis_tlast,
   input  logic [NUM_CH-1:0]        m_axis_tready,
   output logic                     busy,
`ifdef AXIS_DEMUX_DROP_CNT_EN
   output logic [15:0]              drop_cnt,
`endif
   output logic [6:0]               cur_ch
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUTE = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   localparam logic [7:0] NUM_CH_C = 8'(NUM_CH);

   logic [1:0]        state;
   logic              out_valid;
   logic              out_last;
   logic [6:0]        out_ch;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              sel_ok;
   logic              accept;
   logic              load;
   logic              pop;

   assign sel_ok = bus_sel[7] && ({1'b0, bus_sel[6:0]} < NUM_CH_C);

   // Decode the held channel against the ready vector without a wide variable index.
   always_comb begin
      out_ready     = 1'b0;
      m_axis_tvalid = '0;
      m_axis_tlast  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (out_ch == 7'(i)) begin
            out_ready        = m_axis_tready[i];
            m_axis_tvalid[i] = out_valid;
            m_axis_tlast[i]  = out_valid && out_last;
         end
      end
   end

   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         ROUTE:   s_axis_tready = !out_valid || out_ready;
         DROP:    s_axis_tready = 1'b1;
         default: s_axis_tready = 1'b0;
      endcase
   end

   assign accept       = s_axis_tvalid && s_axis_tready;
   assign load         = accept && (state == ROUTE);
   assign pop          = out_valid && out_ready;
   assign m_axis_tdata = {NUM_CH{out_data}};
   assign busy         = (state != IDLE) || out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_ch    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_axis_tvalid) begin
                  if (sel_ok) begin
                     cur_ch <= bus_sel[6:0];
                     state  <= ROUTE;
                  end else begin
                     state  <= DROP;
                  end
               end
            end
            ROUTE:   if (accept && s_axis_tlast) state <= IDLE;
            DROP:    if (accept && s_axis_tlast) state <= IDLE;
            default: state <= IDLE;
         endcase

         // A load overrides a pop so back-to-back beats stream at full rate.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= s_axis_tdata;
            out_last  <= s_axis_tlast;
            out_ch    <= cur_ch;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef AXIS_DEMUX_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if ((state == DROP) && accept && s_axis_tlast && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_pkt_demux.sv
// tb/tb_axis_pkt_demux.sv - self-checking bench for axis_pkt_demux against a beat-queue reference model.
module tb_axis_pkt_demux;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [6:0]  ch;
      logic        last;
      logic [31:0] data;
   } beat_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [7:0]               bus_sel = '0;
   logic [DATA_W-1:0]        s_axis_tdata = '0;
   logic                     s_axis_tvalid = 1'b0;
   logic                     s_axis_tlast = 1'b0;
   logic                     s_axis_tready;
   logic [NUM_CH*DATA_W-1:0] m_axis_tdata;
   logic [NUM_CH-1:0]        m_axis_tvalid;
   logic [NUM_CH-1:0]        m_axis_tlast;
   logic [NUM_CH-1:0]        m_axis_tready = '1;
   logic                     busy;
   logic [6:0]               cur_ch;
`ifdef AXIS_DEMUX_DROP_CNT_EN
   logic [15:0]              drop_cnt;
`endif

   int    checks = 0;
   int    errors = 0;
   int    exp_drops = 0;
   bit    mon_en = 1'b0;
   bit    bp_en = 1'b0;
   bit    rdy_seen = 1'b0;
   beat_t exp_q[$];

   axis_pkt_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus_sel       (bus_sel),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
`ifdef AXIS_DEMUX_DROP_CNT_EN
      .drop_cnt      (drop_cnt),
`endif
      .cur_ch        (cur_ch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] lane(input int i);
      return m_axis_tdata[i*DATA_W +: DATA_W];
   endfunction

   // Every master handshake must match the oldest beat the model expects, in global order.
   task automatic monitor();
      beat_t got;
      beat_t e;
      for (int i = 0; i < NUM_CH; i++) begin
         if (m_axis_tvalid[i] && m_axis_tready[i]) begin
            got.ch   = 7'(i);
            got.last = m_axis_tlast[i];
            got.data = lane(i);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{ch: 7'h7f, last: 1'b0, data: 32'h0};
            check("beat", 64'(got), 64'(e));
         end
      end
      if (|m_axis_tvalid) check("onehot_valid", 64'($countones(m_axis_tvalid) <= 1), 64'd1);
   endtask

   task automatic tick();
      @(negedge clk);
      rdy_seen = s_axis_tvalid && s_axis_tready;
      if (mon_en) monitor();
      @(posedge clk);
      #1;
      if (bp_en) m_axis_tready = NUM_CH'($urandom);
   endtask

   task automatic wait_accept();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!rdy_seen && n < 300);
      if (!rdy_seen) check("accept_timeout", 64'(rdy_seen), 64'd1);
   endtask

   task automatic send_pkt(input logic [7:0] sel, input int len, input logic [31:0] base,
                           input logic [7:0] sel_after);
      bit ok = sel[7] && (int'(sel[6:0]) < NUM_CH);
      bus_sel = sel;
      for (int b = 0; b < len; b++) begin
         s_axis_tdata  = base + 32'(b);
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (b == len - 1);
         wait_accept();
         if (ok) exp_q.push_back('{ch: sel[6:0], last: (b == len - 1), data: base + 32'(b)});
         bus_sel = sel_after;
      end
      if (!ok) exp_drops++;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      tick();
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [7:0] sel;
      int         r;

      // Reset state
      tick();
      tick();
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_tdata", 64'(m_axis_tdata), 64'd0);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cur_ch", 64'(cur_ch), 64'd0);
      rst_n = 1'b1;
      tick();
      mon_en = 1'b1;

      // 3-beat packet to ch2 with full throughput
      exp_q.push_back('{ch: 7'd2, last: 1'b0, data: 32'h11});
      exp_q.push_back('{ch: 7'd2, last: 1'b0, data: 32'h22});
      exp_q.push_back('{ch: 7'd2, last: 1'b1, data: 32'h33});
      bus_sel = 8'h82;
      s_axis_tdata = 32'h11;
      s_axis_tvalid = 1'b1;
      s_axis_tlast = 1'b0;
      #1;
      check("t1_idle_ready", 64'(s_axis_tready), 64'd0);
      tick();
      check("t1_route_ready", 64'(s_axis_tready), 64'd1);
      check("t1_cur_ch", 64'(cur_ch), 64'd2);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_no_valid_yet", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("t1_b0_valid", 64'(m_axis_tvalid), 64'b0100);
      check("t1_b0_data", 64'(lane(2)), 64'h11);
      s_axis_tdata = 32'h22;
      tick();
      check("t1_b1_data", 64'(lane(2)), 64'h22);
      check("t1_b1_last", 64'(m_axis_tlast), 64'd0);
      s_axis_tdata = 32'h33;
      s_axis_tlast = 1'b1;
      tick();
      check("t1_b2_valid", 64'(m_axis_tvalid), 64'b0100);
      check("t1_b2_last", 64'(m_axis_tlast), 64'b0100);
      check("t1_b2_data", 64'(lane(2)), 64'h33);
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      tick();
      check("t1_idle_valid", 64'(m_axis_tvalid), 64'd0);
      check("t1_busy_fall", 64'(busy), 64'd0);
      check("t1_drained", 64'(exp_q.size()), 64'd0);

      // bus_sel change mid-packet is ignored
      send_pkt(8'h81, 4, 32'hA100, 8'h83);
      drain("t2_drained");

      // Dropped packets: bit7 clear, then index out of range
      bus_sel = 8'h05;
      s_axis_tdata = 32'hD000;
      s_axis_tvalid = 1'b1;
      s_axis_tlast = 1'b0;
      tick();
      check("t3_drop_ready", 64'(s_axis_tready), 64'd1);
      check("t3_drop_busy", 64'(busy), 64'd1);
      wait_accept();
      s_axis_tdata = 32'hD001;
      s_axis_tlast = 1'b1;
      wait_accept();
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      exp_drops++;
      send_pkt(8'h84, 2, 32'hD100, 8'h84);
      tick();
      check("t3_no_valid", 64'(m_axis_tvalid), 64'd0);
`ifdef AXIS_DEMUX_DROP_CNT_EN
      check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

      // ch0 tlast held under backpressure while the next ch1 packet waits
      m_axis_tready = '1;
      send_pkt(8'h80, 2, 32'hB000, 8'h80);
      m_axis_tready[0] = 1'b0;
      bus_sel = 8'h81;
      s_axis_tdata = 32'hB100;
      s_axis_tvalid = 1'b1;
      s_axis_tlast = 1'b0;
      exp_q.push_back('{ch: 7'd1, last: 1'b0, data: 32'hB100});
      tick();
      check("t4_hold_valid", 64'(m_axis_tvalid), 64'b0001);
      check("t4_hold_data", 64'(lane(0)), 64'hB001);
      check("t4_hold_last", 64'(m_axis_tlast), 64'b0001);
      check("t4_wait_ready", 64'(s_axis_tready), 64'd0);
      tick();
      check("t4_hold2_valid", 64'(m_axis_tvalid), 64'b0001);
      check("t4_hold2_data", 64'(lane(0)), 64'hB001);
      check("t4_wait2_ready", 64'(s_axis_tready), 64'd0);
      m_axis_tready[0] = 1'b1;
      #1;
      check("t4_release_ready", 64'(s_axis_tready), 64'd1);
      tick();
      check("t4_ch1_valid", 64'(m_axis_tvalid), 64'b0010);
      check("t4_ch1_data", 64'(lane(1)), 64'hB100);
      s_axis_tdata = 32'hB101;
      s_axis_tlast = 1'b1;
      exp_q.push_back('{ch: 7'd1, last: 1'b1, data: 32'hB101});
      wait_accept();
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      drain("t4_drained");

      // Asynchronous reset mid-packet with a held beat on ch3
      mon_en = 1'b0;
      m_axis_tready = 4'b0111;
      bus_sel = 8'h83;
      s_axis_tdata = 32'hC000;
      s_axis_tvalid = 1'b1;
      s_axis_tlast = 1'b0;
      tick();
      tick();
      check("t5_pre_valid", 64'(m_axis_tvalid), 64'b1000);
      s_axis_tdata = 32'hC001;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 64'(m_axis_tvalid), 64'd0);
      check("t5_rst_last", 64'(m_axis_tlast), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_ready", 64'(s_axis_tready), 64'd0);
`ifdef AXIS_DEMUX_DROP_CNT_EN
      check("t5_rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
      exp_drops = 0;
      tick();
      rst_n = 1'b1;
      m_axis_tready = '1;
      #1;
      check("t5_idle_ready", 64'(s_axis_tready), 64'd0);
      check("t5_idle_busy", 64'(busy), 64'd0);
      exp_q.delete();
      exp_q.push_back('{ch: 7'd3, last: 1'b0, data: 32'hC001});
      exp_q.push_back('{ch: 7'd3, last: 1'b1, data: 32'hC002});
      mon_en = 1'b1;
      wait_accept();
      s_axis_tdata = 32'hC002;
      s_axis_tlast = 1'b1;
      wait_accept();
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      drain("t5_drained");

      // Random packets over all channels with random backpressure
      bp_en = 1'b1;
      for (int p = 0; p < 100; p++) begin
         r = $urandom_range(0, 9);
         if (r < 8) sel = {1'b1, 7'($urandom_range(0, NUM_CH - 1))};
         else if (r == 8) sel = {1'b0, 7'($urandom)};
         else sel = {1'b1, 7'($urandom_range(NUM_CH, 127))};
         send_pkt(sel, $urandom_range(1, 6), $urandom, 8'($urandom));
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      bp_en = 1'b0;
      m_axis_tready = '1;
      drain("t6_drained");
`ifdef AXIS_DEMUX_DROP_CNT_EN
      check("t6_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
